// File: rtl/pr_free_list.sv
// Physical-register free list: per-PR FREE/OWNED/DRAIN ownership, same-cycle grants, idle-gated reclaim.
// Optional PRALLOC_ROUND_ROBIN_EN starts the FREE search at a rotating pointer instead of the pool base.
module pr_free_list #(
  parameter int NUM_PHY_REGS  = 64,
  parameter int NUM_SICS      = 2,
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_SICS-1:0]                           alloc_req,
  output logic [NUM_SICS-1:0]                           alloc_gnt,
  output logic [NUM_SICS-1:0]                           alloc_wen,
  output logic [NUM_SICS-1:0][$clog2(NUM_PHY_REGS)-1:0] alloc_pr,
  input  logic [NUM_SICS-1:0]                           release_valid,
  input  logic [NUM_SICS-1:0][$clog2(NUM_PHY_REGS)-1:0] release_pr,
  input  logic [NUM_PHY_REGS-1:0]                       pr_not_idle,
  output logic [$clog2(NUM_PHY_REGS):0]                 free_count,
  output logic                                          empty
);
  localparam int PW   = $clog2(NUM_PHY_REGS);
  localparam int CW   = PW + 1;
  localparam int POOL = NUM_PHY_REGS - NUM_ARCH_REGS;

  typedef enum logic [1:0] {PR_FREE = 2'd0, PR_OWNED = 2'd1, PR_DRAIN = 2'd2} pr_state_e;

  pr_state_e         pr_state [NUM_PHY_REGS];
  logic [NUM_PHY_REGS-1:0] taken;
  logic [NUM_PHY_REGS-1:0] release_hit;
  logic [NUM_PHY_REGS-1:0] reclaim;
  logic [CW-1:0]     grant_cnt;
  logic [CW-1:0]     reclaim_cnt;
  logic              found;
  int                idx_i;
`ifdef PRALLOC_ROUND_ROBIN_EN
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     last_pr;
`endif

  // Each requester in priority order takes the first FREE PR not already claimed this cycle.
  always_comb begin
    taken     = '0;
    alloc_gnt = '0;
    alloc_pr  = '0;
    grant_cnt = '0;
    found     = 1'b0;
    idx_i     = 0;
`ifdef PRALLOC_ROUND_ROBIN_EN
    last_pr   = rr_ptr;
`endif
    for (int s = 0; s < NUM_SICS; s++) begin
      found = 1'b0;
      if (alloc_req[s] && !rst) begin
        for (int k = 0; k < POOL; k++) begin
`ifdef PRALLOC_ROUND_ROBIN_EN
          idx_i = int'(rr_ptr) + k;
          if (idx_i >= NUM_PHY_REGS) idx_i = idx_i - POOL;
`else
          idx_i = NUM_ARCH_REGS + k;
`endif
          if (!found && pr_state[idx_i[PW-1:0]] == PR_FREE && !taken[idx_i[PW-1:0]]) begin
            found                  = 1'b1;
            taken[idx_i[PW-1:0]]   = 1'b1;
            alloc_gnt[s]           = 1'b1;
            alloc_pr[s]            = idx_i[PW-1:0];
            grant_cnt              = grant_cnt + CW'(1);
`ifdef PRALLOC_ROUND_ROBIN_EN
            last_pr                = idx_i[PW-1:0];
`endif
          end
        end
      end
    end
  end

  assign alloc_wen = alloc_gnt;

  // Architectural PRs are never released; out-of-range indices are dropped.
  always_comb begin
    release_hit = '0;
    for (int s = 0; s < NUM_SICS; s++) begin
      if (release_valid[s] && int'(release_pr[s]) >= NUM_ARCH_REGS
          && int'(release_pr[s]) < NUM_PHY_REGS)
        release_hit[release_pr[s]] = 1'b1;
    end
  end

  always_comb begin
    reclaim     = '0;
    reclaim_cnt = '0;
    for (int i = 0; i < NUM_PHY_REGS; i++) begin
      if (pr_state[i] == PR_DRAIN && !pr_not_idle[i]) begin
        reclaim[i]  = 1'b1;
        reclaim_cnt = reclaim_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHY_REGS; i++)
        pr_state[i] <= (i < NUM_ARCH_REGS) ? PR_OWNED : PR_FREE;
      free_count <= CW'(POOL);
    end else begin
      for (int i = 0; i < NUM_PHY_REGS; i++) begin
        if (taken[i])
          pr_state[i] <= PR_OWNED;
        else if (release_hit[i] && pr_state[i] == PR_OWNED)
          pr_state[i] <= PR_DRAIN;
        else if (reclaim[i])
          pr_state[i] <= PR_FREE;
      end
      free_count <= free_count - grant_cnt + reclaim_cnt;
    end
  end

`ifdef PRALLOC_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= PW'(NUM_ARCH_REGS);
    else if (|alloc_gnt)
      rr_ptr <= (int'(last_pr) == NUM_PHY_REGS - 1) ? PW'(NUM_ARCH_REGS) : last_pr + PW'(1);
  end
`endif

  assign empty = (free_count == '0);

`ifndef SYNTHESIS
  function automatic int count_free();
    int n = 0;
    for (int i = 0; i < NUM_PHY_REGS; i++)
      if (pr_state[i] == PR_FREE) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SICS; s++) begin
        if (release_valid[s] && int'(release_pr[s]) >= NUM_ARCH_REGS
            && pr_state[release_pr[s]] != PR_OWNED)
          $fatal(1, "pr_free_list: release of non-owned PR %0d", release_pr[s]);
        for (int t = s + 1; t < NUM_SICS; t++)
          if (release_valid[s] && release_valid[t] && release_pr[s] == release_pr[t]
              && int'(release_pr[s]) >= NUM_ARCH_REGS)
            $fatal(1, "pr_free_list: duplicate release of PR %0d", release_pr[s]);
      end
      if (count_free() != int'(free_count))
        $fatal(1, "pr_free_list: free_count %0d disagrees with state array", free_count);
    end
  end
`endif
endmodule

// File: tb/tb_pr_free_list.sv
// Directed bench for pr_free_list (default lowest-index-first build).
module tb_pr_free_list;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       alloc_req;
  logic [1:0]       alloc_gnt;
  logic [1:0]       alloc_wen;
  logic [1:0][5:0]  alloc_pr;
  logic [1:0]       release_valid;
  logic [1:0][5:0]  release_pr;
  logic [63:0]      pr_not_idle;
  logic [6:0]       free_count;
  logic             empty;

  int errors = 0;
  int checks = 0;

  pr_free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_wen(alloc_wen), .alloc_pr(alloc_pr), .release_valid(release_valid),
    .release_pr(release_pr), .pr_not_idle(pr_not_idle), .free_count(free_count),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_req     = 2'b00;
    release_valid = 2'b00;
    release_pr    = '0;
  endtask

  // Advance to the next falling edge (one rising edge in between).
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    pr_not_idle = '0;
    alloc_req = 2'b11;
    #1;
    chk("rst_gnt", 32'(alloc_gnt), 0);
    chk("rst_wen", 32'(alloc_wen), 0);
    chk("rst_pr0", 32'(alloc_pr[0]), 0);
    chk("rst_fc", 32'(free_count), 32);
    chk("rst_empty", 32'(empty), 0);
    step(); step();
    rst = 1'b0;

    // Dual grant from reset
    alloc_req = 2'b11;
    #1;
    chk("dual_gnt", 32'(alloc_gnt), 3);
    chk("dual_wen", 32'(alloc_wen), 3);
    chk("dual_pr0", 32'(alloc_pr[0]), 32);
    chk("dual_pr1", 32'(alloc_pr[1]), 33);
    step();
    alloc_req = 2'b00;
    #1;
    chk("dual_fc", 32'(free_count), 30);

    // Drain the pool with single grants
    for (int i = 0; i < 30; i++) begin
      alloc_req = 2'b01;
      #1;
      chk("drain_gnt", 32'(alloc_gnt), 1);
      chk("drain_pr", 32'(alloc_pr[0]), 32'(34 + i));
      step();
    end
    alloc_req = 2'b11;
    #1;
    chk("empty_gnt", 32'(alloc_gnt), 0);
    chk("empty_pr0", 32'(alloc_pr[0]), 0);
    chk("empty_fc", 32'(free_count), 0);
    chk("empty_flag", 32'(empty), 1);

    // Release 40 while busy: stays DRAIN
    idle_inputs();
    pr_not_idle = '0;
    pr_not_idle[40] = 1'b1;
    release_valid = 2'b01;
    release_pr[0] = 6'd40;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      alloc_req = 2'b01;
      #1;
      chk("drain_busy_gnt", 32'(alloc_gnt), 0);
      chk("drain_busy_fc", 32'(free_count), 0);
      step();
    end
    pr_not_idle[40] = 1'b0;
    alloc_req = 2'b01;
    #1;
    chk("reclaim_cycle_gnt", 32'(alloc_gnt), 0);
    step();
    alloc_req = 2'b00;
    #1;
    chk("reclaim_fc", 32'(free_count), 1);
    chk("reclaim_empty", 32'(empty), 0);
    alloc_req = 2'b01;
    #1;
    chk("regrant_gnt", 32'(alloc_gnt), 1);
    chk("regrant_pr", 32'(alloc_pr[0]), 40);
    step();
    idle_inputs();
    #1;
    chk("regrant_fc", 32'(free_count), 0);

    // Put 34 and 50 into DRAIN; 34 reclaims, 50 held busy
    pr_not_idle[50] = 1'b1;
    release_valid = 2'b11;
    release_pr[0] = 6'd34;
    release_pr[1] = 6'd50;
    step();
    idle_inputs();
    step();
    #1;
    chk("prep_fc", 32'(free_count), 1);

    // Same edge: grant 34, release 33, reclaim 50
    pr_not_idle[50] = 1'b0;
    alloc_req = 2'b01;
    release_valid = 2'b10;
    release_pr[1] = 6'd33;
    #1;
    chk("simul_gnt", 32'(alloc_gnt), 1);
    chk("simul_pr0", 32'(alloc_pr[0]), 34);
    step();
    idle_inputs();
    pr_not_idle = '1;
    #1;
    chk("simul_fc", 32'(free_count), 1);
    alloc_req = 2'b11;
    #1;
    chk("post_simul_gnt", 32'(alloc_gnt), 1);
    chk("post_simul_pr0", 32'(alloc_pr[0]), 50);
    chk("post_simul_pr1", 32'(alloc_pr[1]), 0);
    step();
    idle_inputs();
    pr_not_idle = '0;
    #1;
    chk("post50_fc", 32'(free_count), 0);
    step();
    #1;
    chk("reclaim33_fc", 32'(free_count), 1);
    alloc_req = 2'b10;
    #1;
    chk("sic1_gnt", 32'(alloc_gnt), 2);
    chk("sic1_pr1", 32'(alloc_pr[1]), 33);
    chk("sic1_pr0", 32'(alloc_pr[0]), 0);
    step();
    idle_inputs();

    // Architectural releases are ignored
    release_valid = 2'b11;
    release_pr[0] = 6'd5;
    release_pr[1] = 6'd0;
    step();
    idle_inputs();
    step();
    alloc_req = 2'b01;
    #1;
    chk("arch_rel_fc", 32'(free_count), 0);
    chk("arch_rel_gnt", 32'(alloc_gnt), 0);

    // Asynchronous reset mid-sequence
    alloc_req = 2'b11;
    #1;
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(alloc_gnt), 0);
    chk("async_pr1", 32'(alloc_pr[1]), 0);
    chk("async_fc", 32'(free_count), 32);
    chk("async_empty", 32'(empty), 0);
    step();
    rst = 1'b0;
    #1;
    chk("after_rst_gnt", 32'(alloc_gnt), 3);
    chk("after_rst_pr0", 32'(alloc_pr[0]), 32);
    chk("after_rst_pr1", 32'(alloc_pr[1]), 33);
    step();
    idle_inputs();
    #1;
    chk("after_rst_fc", 32'(free_count), 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
